// File: rtl/axi4_master_txn_sched.sv
// axi4_master_txn_sched
// Round-robin scheduler that shares one AXI4 master traffic engine among
// NREQ requesters. It grants one requester at a time and runs the engine's
// init/done/error handshake. It returns a per-requester completion pulse
// with error status, and keeps saturating transaction and error counters.
//
// Optional watchdog: define AXI4_MASTER_TXN_SCHED_TIMEOUT_EN to build a
// wait-state counter. When it expires, the transaction is forced to
// complete with err_o=1 and a timeout_o pulse. Without the macro, the
// scheduler waits for the engine indefinitely and timeout_o is tied low.

module axi4_master_txn_sched #(
    parameter int NREQ              = 2,
    parameter int INIT_PULSE_CYCLES = 2,
    parameter int TIMEOUT_CYCLES    = 4096,
    parameter int CNT_W             = 16
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic [NREQ-1:0]  req_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [NREQ-1:0]  done_o,
    output logic             err_o,
    output logic             busy_o,
    output logic             M_AXI_INIT_AXI_TXN,
    input  logic             M_AXI_TXN_DONE,
    input  logic             M_AXI_ERROR,
    output logic [CNT_W-1:0] txn_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             timeout_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IW = $clog2(INIT_PULSE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_LOW,   // engine done still high from the previous transaction
        S_WAIT_DONE,
        S_COMPLETE
    } state_t;

    state_t         state;
    logic [PW-1:0]  ptr;        // requester currently holding highest priority
    logic [IW-1:0]  init_cnt;
    logic [PW-1:0]  win_idx;
    logic [PW:0]    cand;
    logic [NREQ-1:0] win_onehot;
    logic [PW-1:0]  ptr_next;
    logic           any_req;
    logic           wd_hit;

    // Round-robin pick: walk from lowest to highest priority so the
    // highest-priority active requester is the last one to be written
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        win_idx    = '0;
        cand       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(NREQ))
                cand = cand - (PW+1)'(NREQ);
            if (req_i[cand[PW-1:0]])
                win_idx = cand[PW-1:0];
        end
        win_onehot = NREQ'(1) << win_idx;
    end

    assign any_req  = |req_i;
    assign ptr_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

`ifdef AXI4_MASTER_TXN_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wd_cnt;
    logic          timeout_q;

    assign wd_hit    = (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign timeout_o = timeout_q;

    // Watchdog: count cycles spent waiting on the engine, restart on each init
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_hit && ((state == S_WAIT_LOW) ||
                                    (state == S_WAIT_DONE && !M_AXI_TXN_DONE));
            if (state == S_INIT)
                wd_cnt <= '0;
            else if (state == S_WAIT_LOW || state == S_WAIT_DONE)
                wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign wd_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Transaction FSM with registered grant, init, completion and counters
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state              <= S_IDLE;
            ptr                <= '0;
            init_cnt           <= '0;
            gnt_o              <= '0;
            done_o             <= '0;
            err_o              <= 1'b0;
            busy_o             <= 1'b0;
            M_AXI_INIT_AXI_TXN <= 1'b0;
            txn_cnt_o          <= '0;
            err_cnt_o          <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            done_o <= '0;
            err_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        state              <= S_INIT;
                        gnt_o              <= win_onehot;
                        ptr                <= ptr_next;
                        busy_o             <= 1'b1;
                        M_AXI_INIT_AXI_TXN <= 1'b1;
                        init_cnt           <= '0;
                    end
                end
                S_INIT: begin
                    if (init_cnt == IW'(INIT_PULSE_CYCLES - 1)) begin
                        state              <= S_WAIT_LOW;
                        M_AXI_INIT_AXI_TXN <= 1'b0;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                S_WAIT_LOW: begin
                    if (wd_hit) begin
                        state  <= S_COMPLETE;
                        done_o <= gnt_o;
                        err_o  <= 1'b1;
                    end else if (!M_AXI_TXN_DONE) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (M_AXI_TXN_DONE) begin
                        state  <= S_COMPLETE;
                        done_o <= gnt_o;
                        err_o  <= M_AXI_ERROR;
                    end else if (wd_hit) begin
                        state  <= S_COMPLETE;
                        done_o <= gnt_o;
                        err_o  <= 1'b1;
                    end
                end
                S_COMPLETE: begin
                    state  <= S_IDLE;
                    gnt_o  <= '0;
                    busy_o <= 1'b0;
                    if (txn_cnt_o != '1)
                        txn_cnt_o <= txn_cnt_o + 1'b1;
                    if (err_o && (err_cnt_o != '1))
                        err_cnt_o <= err_cnt_o + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
